// File: rtl/sram_port_arbiter_if.sv
// Request/response and SRAM-side signals of the shared single-port SRAM arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the SRAM.
interface sram_port_arbiter_if;
    logic        i_req;
    logic [31:0] i_addr;
    logic        i_addr_ok;
    logic        i_data_ok;
    logic [31:0] i_rdata;

    logic        d_req;
    logic        d_wr;
    logic [3:0]  d_wstrb;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic        d_addr_ok;
    logic        d_data_ok;
    logic [31:0] d_rdata;

    logic        sram_en;
    logic [3:0]  sram_we;
    logic [31:0] sram_addr;
    logic [31:0] sram_wdata;
    logic [31:0] sram_rdata;

    modport slave (
        input  i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, sram_rdata,
        output i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
               sram_en, sram_we, sram_addr, sram_wdata
    );

    modport master (
        output i_req, i_addr, d_req, d_wr, d_wstrb, d_addr, d_wdata, sram_rdata,
        input  i_addr_ok, i_data_ok, i_rdata, d_addr_ok, d_data_ok, d_rdata,
               sram_en, sram_we, sram_addr, sram_wdata
    );
endinterface

// File: rtl/sram_port_arbiter.sv
// Shares one synchronous single-port SRAM between fetch and data requesters.
// Data has priority; fetch is forced through after STARVE_LIMIT consecutive data wins.
module sram_port_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                     clk,
    input  logic                     resetn,
    sram_port_arbiter_if.slave       bus
);
    typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
    localparam logic OWN_I = 1'b0;
    localparam logic OWN_D = 1'b1;
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    state_t     state_q, state_d;
    logic       owner_q, owner_d;
    logic       wr_q, wr_d;
    logic [3:0] starve_q, starve_d;

    logic grant_i, grant_d;
    logic starved;

    // Grants are gated by resetn so every output is zero while reset is held.
    assign starved = (starve_q == LIMIT);
    assign grant_d = resetn && (state_q == IDLE) && bus.d_req && !(bus.i_req && starved);
    assign grant_i = resetn && (state_q == IDLE) && bus.i_req && !grant_d;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            owner_q  <= OWN_I;
            wr_q     <= 1'b0;
            starve_q <= 4'd0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            wr_q     <= wr_d;
            starve_q <= starve_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        owner_d  = owner_q;
        wr_d     = wr_q;
        starve_d = starve_q;
        case (state_q)
            IDLE: begin
                if (grant_i) begin
                    state_d  = WAIT;
                    owner_d  = OWN_I;
                    wr_d     = 1'b0;
                    starve_d = 4'd0;
                end else if (grant_d) begin
                    state_d  = WAIT;
                    owner_d  = OWN_D;
                    wr_d     = bus.d_wr;
                    if (!bus.i_req)
                        starve_d = 4'd0;
                    else if (starve_q != LIMIT)
                        starve_d = starve_q + 4'd1;
                end
            end
            WAIT:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // data_ok depends only on registered state; sram_rdata only feeds the rdata outputs.
    always_comb begin
        bus.i_addr_ok  = grant_i;
        bus.d_addr_ok  = grant_d;
        bus.sram_en    = grant_i | grant_d;
        bus.sram_we    = 4'd0;
        bus.sram_addr  = 32'd0;
        bus.sram_wdata = 32'd0;
        if (grant_i) begin
            bus.sram_addr = bus.i_addr;
        end else if (grant_d) begin
            bus.sram_addr  = bus.d_addr;
            bus.sram_wdata = bus.d_wdata;
            bus.sram_we    = bus.d_wr ? bus.d_wstrb : 4'd0;
        end
        bus.i_data_ok = (state_q == WAIT) && (owner_q == OWN_I);
        bus.d_data_ok = (state_q == WAIT) && (owner_q == OWN_D);
        bus.i_rdata   = bus.i_data_ok ? bus.sram_rdata : 32'd0;
        bus.d_rdata   = (bus.d_data_ok && !wr_q) ? bus.sram_rdata : 32'd0;
    end
endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter with a byte-writable SRAM model behind the port.
module tb_sram_port_arbiter;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   vectors = 0;
    int   fails = 0;

    sram_port_arbiter_if sif ();

    sram_port_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (sif)
    );

    always #5 clk = ~clk;

    // Word-indexed SRAM model: read data appears the cycle after sram_en.
    logic [31:0] mem [256];
    logic [31:0] rd_q = 32'd0;
    assign sif.sram_rdata = rd_q;

    always @(posedge clk) begin
        if (sif.sram_en) begin
            rd_q <= mem[sif.sram_addr[9:2]];
            for (int b = 0; b < 4; b++)
                if (sif.sram_we[b]) mem[sif.sram_addr[9:2]][b*8 +: 8] <= sif.sram_wdata[b*8 +: 8];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge; inputs are changed here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".i_addr_ok"},  {31'd0, sif.i_addr_ok}, 32'd0);
        chk({tag, ".d_addr_ok"},  {31'd0, sif.d_addr_ok}, 32'd0);
        chk({tag, ".i_data_ok"},  {31'd0, sif.i_data_ok}, 32'd0);
        chk({tag, ".d_data_ok"},  {31'd0, sif.d_data_ok}, 32'd0);
        chk({tag, ".sram_en"},    {31'd0, sif.sram_en},   32'd0);
        chk({tag, ".sram_we"},    {28'd0, sif.sram_we},   32'd0);
        chk({tag, ".sram_addr"},  sif.sram_addr,  32'd0);
        chk({tag, ".sram_wdata"}, sif.sram_wdata, 32'd0);
        chk({tag, ".i_rdata"},    sif.i_rdata,    32'd0);
        chk({tag, ".d_rdata"},    sif.d_rdata,    32'd0);
    endtask

    task automatic set_d(input logic req, input logic wr, input logic [3:0] strb,
                         input logic [31:0] addr, input logic [31:0] wdata);
        sif.d_req   = req;
        sif.d_wr    = wr;
        sif.d_wstrb = strb;
        sif.d_addr  = addr;
        sif.d_wdata = wdata;
    endtask

    initial begin
        logic exp_d;
        for (int k = 0; k < 256; k++) mem[k] = 32'd0;
        mem[0] = 32'h02bffc63;  // word at 0x1c000000

        sif.i_req  = 1'b1;
        sif.i_addr = 32'h1c000000;
        set_d(1'b1, 1'b1, 4'hf, 32'h100, 32'h12345678);

        // Reset held with both requests high: every output must stay zero.
        tick();
        settle();
        chk_all_zero("reset");
        tick();
        sif.i_req = 1'b0;
        set_d(1'b0, 1'b0, 4'h0, 32'h0, 32'h0);
        resetn = 1'b1;

        // Fetch only.
        tick();
        sif.i_req = 1'b1;
        settle();
        chk("fetch.addr_ok", {31'd0, sif.i_addr_ok}, 32'd1);
        chk("fetch.sram_en", {31'd0, sif.sram_en}, 32'd1);
        chk("fetch.sram_addr", sif.sram_addr, 32'h1c000000);
        chk("fetch.sram_we", {28'd0, sif.sram_we}, 32'd0);
        tick();
        sif.i_req = 1'b0;
        settle();
        chk("fetch.data_ok", {31'd0, sif.i_data_ok}, 32'd1);
        chk("fetch.rdata", sif.i_rdata, 32'h02bffc63);
        chk("fetch.wait_no_en", {31'd0, sif.sram_en}, 32'd0);
        tick();
        settle();
        chk("fetch.idle_no_ok", {31'd0, sif.i_data_ok}, 32'd0);

        // Full write, then readback.
        set_d(1'b1, 1'b1, 4'hf, 32'h100, 32'hdeadbeef);
        settle();
        chk("wr.addr_ok", {31'd0, sif.d_addr_ok}, 32'd1);
        chk("wr.sram_we", {28'd0, sif.sram_we}, 32'hf);
        chk("wr.sram_wdata", sif.sram_wdata, 32'hdeadbeef);
        chk("wr.sram_addr", sif.sram_addr, 32'h100);
        tick();
        sif.d_req = 1'b0;
        settle();
        chk("wr.data_ok", {31'd0, sif.d_data_ok}, 32'd1);
        chk("wr.rdata_zero", sif.d_rdata, 32'd0);
        chk("wr.wait_wdata_zero", sif.sram_wdata, 32'd0);
        chk("wr.wait_addr_ok", {31'd0, sif.d_addr_ok}, 32'd0);
        tick();
        set_d(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        settle();
        chk("rd1.addr_ok", {31'd0, sif.d_addr_ok}, 32'd1);
        chk("rd1.sram_we", {28'd0, sif.sram_we}, 32'd0);
        tick();
        sif.d_req = 1'b0;
        settle();
        chk("rd1.data_ok", {31'd0, sif.d_data_ok}, 32'd1);
        chk("rd1.rdata", sif.d_rdata, 32'hdeadbeef);

        // Partial write of the low half-word, then readback.
        tick();
        set_d(1'b1, 1'b1, 4'h3, 32'h100, 32'h00001234);
        settle();
        chk("pwr.sram_we", {28'd0, sif.sram_we}, 32'h3);
        tick();
        sif.d_req = 1'b0;
        settle();
        chk("pwr.data_ok", {31'd0, sif.d_data_ok}, 32'd1);
        tick();
        set_d(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        settle();
        chk("rd2.addr_ok", {31'd0, sif.d_addr_ok}, 32'd1);
        tick();
        settle();
        chk("rd2.rdata", sif.d_rdata, 32'hdead1234);

        // Both requesters continuous: D D D D I D D D D I.
        tick();
        sif.i_req = 1'b1;
        for (int g = 0; g < 10; g++) begin
            exp_d = !(g == 4 || g == 9);
            settle();
            chk($sformatf("starve.g%0d.d_addr_ok", g), {31'd0, sif.d_addr_ok}, {31'd0, exp_d});
            chk($sformatf("starve.g%0d.i_addr_ok", g), {31'd0, sif.i_addr_ok}, {31'd0, !exp_d});
            tick();
            settle();
            chk($sformatf("starve.g%0d.d_data_ok", g), {31'd0, sif.d_data_ok}, {31'd0, exp_d});
            chk($sformatf("starve.g%0d.i_data_ok", g), {31'd0, sif.i_data_ok}, {31'd0, !exp_d});
            chk($sformatf("starve.g%0d.rdata", g), exp_d ? sif.d_rdata : sif.i_rdata,
                exp_d ? 32'hdead1234 : 32'h02bffc63);
            tick();
        end

        // Both raised together right after a fetch grant: data wins, fetch two cycles later.
        sif.i_req = 1'b0;
        sif.d_req = 1'b0;
        settle();
        chk("race.idle_quiet", {31'd0, sif.sram_en}, 32'd0);
        tick();
        sif.i_req = 1'b1;
        sif.d_req = 1'b1;
        settle();
        chk("race.d_wins", {31'd0, sif.d_addr_ok}, 32'd1);
        chk("race.i_loses", {31'd0, sif.i_addr_ok}, 32'd0);
        tick();
        sif.d_req = 1'b0;
        settle();
        chk("race.wait_i_blocked", {31'd0, sif.i_addr_ok}, 32'd0);
        chk("race.d_data_ok", {31'd0, sif.d_data_ok}, 32'd1);
        tick();
        settle();
        chk("race.i_granted", {31'd0, sif.i_addr_ok}, 32'd1);
        tick();
        sif.i_req = 1'b0;
        settle();
        chk("race.i_data_ok", {31'd0, sif.i_data_ok}, 32'd1);

        // Reset in WAIT after a read grant drops the transaction.
        tick();
        set_d(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        settle();
        chk("rst.rd_addr_ok", {31'd0, sif.d_addr_ok}, 32'd1);
        tick();
        sif.d_req = 1'b0;
        sif.i_req = 1'b1;
        resetn = 1'b0;
        settle();
        chk_all_zero("rst.in_wait");
        tick();
        settle();
        chk_all_zero("rst.held");
        resetn = 1'b1;
        settle();
        chk("rst.first_accept", {31'd0, sif.i_addr_ok}, 32'd1);
        chk("rst.no_stale_d_ok", {31'd0, sif.d_data_ok}, 32'd0);
        tick();
        sif.i_req = 1'b0;
        settle();
        chk("rst.i_data_ok", {31'd0, sif.i_data_ok}, 32'd1);
        chk("rst.d_data_ok", {31'd0, sif.d_data_ok}, 32'd0);

        // Write with no byte enables: access happens, memory untouched.
        tick();
        set_d(1'b1, 1'b1, 4'h0, 32'h100, 32'hffffffff);
        settle();
        chk("z.sram_en", {31'd0, sif.sram_en}, 32'd1);
        chk("z.sram_we", {28'd0, sif.sram_we}, 32'd0);
        tick();
        sif.d_req = 1'b0;
        settle();
        chk("z.data_ok", {31'd0, sif.d_data_ok}, 32'd1);
        chk("z.rdata_zero", sif.d_rdata, 32'd0);
        tick();
        settle();
        chk("z.data_ok_once", {31'd0, sif.d_data_ok}, 32'd0);
        set_d(1'b1, 1'b0, 4'h0, 32'h100, 32'h0);
        tick();
        sif.d_req = 1'b0;
        settle();
        chk("z.readback", sif.d_rdata, 32'hdead1234);

        tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end
endmodule
